fir_tap_loader: RTL and testbench
=================================

FIR_TAP_LOADER -- requirements
Module: fir_tap_loader

Interface
REQ-001 SHALL have parameters: G_NUM_TAPS, 16, taps per bank; G_TAP_WIDTH, 16, tap bits; G_DATA_WIDTH, 16, sample bits; G_NUM_BANKS, 4, coefficient banks.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low.
- cfg_wr_bank, in, clog2(G_NUM_BANKS), bank select for host write.
- cfg_wr_addr, in, clog2(G_NUM_TAPS), tap index for host write.
- cfg_wr_data, in, G_TAP_WIDTH, tap value.
- cfg_wr_valid, in, 1, host write strobe.
- load_bank, in, clog2(G_NUM_BANKS)+1, requested bank.
- load_valid / load_ready, in / out, 1 each, load-request handshake.
- load_err, out, 1, one-cycle pulse on a rejected request.
- active_bank, out, clog2(G_NUM_BANKS), bank currently in the FIR.
- busy, out, 1, high outside RUN.
- s_din / s_din_valid / s_din_ready, in / in / out, G_DATA_WIDTH / 1 / 1, upstream samples.
- fir_din / fir_din_valid / fir_din_ready, out / out / in, G_DATA_WIDTH / 1 / 1, samples to the FIR.
- fir_dout_valid / fir_dout_ready, in / in, 1 each, FIR output handshake, monitored only.
- fir_enable, out, 1, FIR enable.
- tap_dout / tap_dout_valid / tap_dout_ready, out / out / in, G_TAP_WIDTH / 1 / 1, tap stream to the FIR.

Function
REQ-003 Bank RAM SHALL hold G_NUM_BANKS x G_NUM_TAPS taps; cfg_wr_valid writes in one cycle, in any state.
REQ-004 States SHALL be IDLE, DRAIN, DISABLE, PROGRAM, RUN; IDLE after reset.
REQ-005 load_ready SHALL be 1 in IDLE and RUN only; a request is accepted on load_valid & load_ready.
REQ-006 Accepted load_bank >= G_NUM_BANKS SHALL pulse load_err the next cycle, leave the state unchanged, and ignore the request.
REQ-007 Valid accept in IDLE or RUN SHALL latch the bank and go to DRAIN.
REQ-008 Sample gating: fir_din = s_din; fir_din_valid = s_din_valid & (state==RUN); s_din_ready = fir_din_ready & (state==RUN), all combinational.
REQ-009 In-flight counter (2 bits) SHALL increment on a fir_din handshake and decrement on a fir_dout handshake; both in one cycle leaves it unchanged.
REQ-010 A fir_din handshake coinciding with the load accept SHALL be counted; the FIR receives no further samples until RUN.
REQ-011 DRAIN SHALL exit to DISABLE when in-flight==0, including on the first DRAIN cycle.
REQ-012 DISABLE SHALL hold fir_enable=0 for exactly 2 cycles, then go to PROGRAM.
REQ-013 In PROGRAM, fir_enable=1 and taps 0..G_NUM_TAPS-1 of the latched bank SHALL be streamed in order; tap_dout/tap_dout_valid are held stable until tap_dout_ready.
REQ-014 RAM read latency is 1 cycle; the first tap_dout_valid SHALL occur no later than 2 cycles after PROGRAM entry, with at most one bubble cycle between accepted taps.
REQ-015 After the G_NUM_TAPS-th tap handshake, the block SHALL enter RUN the next cycle and update active_bank.
REQ-016 Completion SHALL be taken from the tap count only; no sticky FIR done flag is used.
REQ-017 In IDLE, fir_enable SHALL be 0; in DRAIN and RUN, fir_enable SHALL be 1.
REQ-018 busy = (state != RUN).
REQ-019 A host write to the bank being streamed SHALL take effect for taps not yet read.

Reset
REQ-020 While reset=0, outputs SHALL be: fir_enable=0, tap_dout_valid=0, tap_dout=0, load_ready=0, load_err=0, active_bank=0, busy=1, s_din_ready=0, fir_din_valid=0; counters and state cleared to IDLE.
REQ-021 Reset mid-PROGRAM or mid-DRAIN SHALL abandon the operation; RAM contents are not cleared.
REQ-022 Reset deassertion SHALL take effect on the next clk edge; load_ready=1 from the first cycle after that edge.

Structure
REQ-023 The state enum and a tap-address width function SHALL live in shared package fir_ctrl_pkg.
REQ-024 The bank RAM SHALL be one sub-module, fir_tap_bank_ram: simple dual-port, 1-cycle registered read.

Verification
REQ-025 Load bank 2 from IDLE (taps 1..16), tap_dout_ready=1 -> 16 taps 1..16 in order, RUN reached, active_bank=2.
REQ-026 Load bank 7 -> load_err single pulse, state IDLE, no taps issued.
REQ-027 In RUN, one sample in flight plus load of bank 1 -> no fir_din_valid, DRAIN until dout handshake, then fir_enable=0 for 2 cycles.
REQ-028 tap_dout_ready toggling 1/0 each cycle -> all 16 taps delivered, values held stable while stalled.
REQ-029 Reset asserted at tap 8 -> all outputs at reset values immediately; a new load of bank 0 streams all 16 taps.
REQ-030 Host write bank1[15]=0x7FFF during bank-1 PROGRAM at tap 3 -> tap 15 equals 0x7FFF.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR tap loader.
//   fir_state_e    : controller state encoding
//   DISABLE_CYCLES : cycles fir_enable is held low between drain and reprogram
//   tap_addr_w()   : index width for an n-entry space (never below 1 bit)
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_DISABLE = 3'd2,
    ST_PROGRAM = 3'd3,
    ST_RUN     = 3'd4
  } fir_state_e;

  localparam int unsigned DISABLE_CYCLES = 2;

  function automatic int unsigned tap_addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_tap_bank_ram.sv
// Coefficient storage: G_NUM_BANKS x G_NUM_TAPS words, simple dual port.
//   clk                       : clock
//   wr_en_i/wr_bank_i/wr_addr_i/wr_data_i : one-cycle write port
//   rd_en_i/rd_bank_i/rd_addr_i          : read request
//   rd_data_o                 : registered read data, valid the cycle after rd_en_i,
//                               held until the next read
// Storage is deliberately not reset so coefficients survive a controller reset.
module fir_tap_bank_ram
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned G_NUM_TAPS  = 16,
  parameter int unsigned G_TAP_WIDTH = 16,
  parameter int unsigned G_NUM_BANKS = 4,
  localparam int unsigned AW = tap_addr_w(G_NUM_TAPS),
  localparam int unsigned BW = tap_addr_w(G_NUM_BANKS)
) (
  input  logic                   clk,
  input  logic                   wr_en_i,
  input  logic [BW-1:0]          wr_bank_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [G_TAP_WIDTH-1:0] wr_data_i,
  input  logic                   rd_en_i,
  input  logic [BW-1:0]          rd_bank_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [G_TAP_WIDTH-1:0] rd_data_o
);

  logic [G_TAP_WIDTH-1:0] mem_q [G_NUM_BANKS][G_NUM_TAPS];
  logic [G_TAP_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_tap_loader.sv
// FIR coefficient bank loader. Swaps the FIR onto a new coefficient bank:
// drains in-flight samples, disables the FIR briefly, streams the bank's taps,
// then returns to running with the new bank active.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no bank loaded yet, FIR disabled, waiting for a load request
//   ST_DRAIN   | new samples blocked, waiting for in-flight count to reach 0
//   ST_DISABLE | fir_enable low for DISABLE_CYCLES cycles
//   ST_PROGRAM | FIR enabled, taps 0..N-1 of the latched bank streamed out
//   ST_RUN     | samples pass through, active_bank valid
//
// Ports:
//   clk, reset (async, active-low)
//   cfg_wr_*            : host write into the coefficient RAM, any state
//   load_bank/valid/ready, load_err : bank-switch request, err pulses on bad bank
//   active_bank, busy   : bank in use, high whenever not in ST_RUN
//   s_din*  -> fir_din* : sample path, gated to ST_RUN
//   fir_dout_valid/ready: FIR output handshake, only counted
//   fir_enable          : FIR enable
//   tap_dout*           : tap stream to the FIR
module fir_tap_loader
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned G_NUM_TAPS   = 16,
  parameter int unsigned G_TAP_WIDTH  = 16,
  parameter int unsigned G_DATA_WIDTH = 16,
  parameter int unsigned G_NUM_BANKS  = 4,
  localparam int unsigned AW  = tap_addr_w(G_NUM_TAPS),
  localparam int unsigned BW  = tap_addr_w(G_NUM_BANKS),
  localparam int unsigned LBW = BW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BW-1:0]           cfg_wr_bank,
  input  logic [AW-1:0]           cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]  cfg_wr_data,
  input  logic                    cfg_wr_valid,
  input  logic [LBW-1:0]          load_bank,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic                    load_err,
  output logic [BW-1:0]           active_bank,
  output logic                    busy,
  input  logic [G_DATA_WIDTH-1:0] s_din,
  input  logic                    s_din_valid,
  output logic                    s_din_ready,
  output logic [G_DATA_WIDTH-1:0] fir_din,
  output logic                    fir_din_valid,
  input  logic                    fir_din_ready,
  input  logic                    fir_dout_valid,
  input  logic                    fir_dout_ready,
  output logic                    fir_enable,
  output logic [G_TAP_WIDTH-1:0]  tap_dout,
  output logic                    tap_dout_valid,
  input  logic                    tap_dout_ready
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]  NUM_TAPS_C  = CW'(G_NUM_TAPS);
  localparam logic [LBW-1:0] NUM_BANKS_C = LBW'(G_NUM_BANKS);
  localparam logic [1:0]     DIS_LOAD_C  = 2'(DISABLE_CYCLES - 1);

  fir_state_e       state_q, state_d;
  logic             rst_done_q;
  logic [BW-1:0]    bank_q, bank_d;
  logic [BW-1:0]    active_q, active_d;
  logic [1:0]       inflight_q, inflight_d;
  logic [1:0]       dis_cnt_q, dis_cnt_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [CW-1:0]    rd_left_q, rd_left_d;
  logic [CW-1:0]    tap_left_q, tap_left_d;
  logic             tap_vld_q, tap_vld_d;
  logic             load_err_q, load_err_d;

  logic             in_run;
  logic             load_acc;
  logic             din_hs;
  logic             dout_hs;
  logic             tap_hs;
  logic             rd_en;
  logic [G_TAP_WIDTH-1:0] rd_data;

  fir_tap_bank_ram #(
    .G_NUM_TAPS  (G_NUM_TAPS),
    .G_TAP_WIDTH (G_TAP_WIDTH),
    .G_NUM_BANKS (G_NUM_BANKS)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (cfg_wr_valid),
    .wr_bank_i (cfg_wr_bank),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (cfg_wr_data),
    .rd_en_i   (rd_en),
    .rd_bank_i (bank_q),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data)
  );

  // rst_done_q keeps load_ready low until the first edge after reset release.
  assign in_run     = (state_q == ST_RUN);
  assign load_ready = rst_done_q & ((state_q == ST_IDLE) | in_run);
  assign load_acc   = load_valid & load_ready;

  assign fir_din       = s_din;
  assign fir_din_valid = s_din_valid & in_run;
  assign s_din_ready   = fir_din_ready & in_run;
  assign din_hs        = fir_din_valid & fir_din_ready;
  assign dout_hs       = fir_dout_valid & fir_dout_ready;

  assign tap_hs         = tap_vld_q & tap_dout_ready;
  assign tap_dout_valid = tap_vld_q;
  // The RAM output register is not reset, so mask it when no tap is presented.
  assign tap_dout       = tap_vld_q ? rd_data : '0;

  assign fir_enable  = (state_q == ST_DRAIN) | (state_q == ST_PROGRAM) | in_run;
  assign busy        = ~in_run;
  assign active_bank = active_q;
  assign load_err    = load_err_q;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    active_d   = active_q;
    inflight_d = inflight_q;
    dis_cnt_d  = dis_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_left_d  = rd_left_q;
    tap_left_d = tap_left_q;
    tap_vld_d  = tap_vld_q;
    load_err_d = 1'b0;
    rd_en      = 1'b0;

    // Saturating so a misbehaving FIR handshake cannot wrap the count.
    if (din_hs && !dout_hs && inflight_q != 2'd3) begin
      inflight_d = inflight_q + 2'd1;
    end else if (dout_hs && !din_hs && inflight_q != 2'd0) begin
      inflight_d = inflight_q - 2'd1;
    end

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_acc) begin
          if (load_bank < NUM_BANKS_C) begin
            bank_d  = load_bank[BW-1:0];
            state_d = ST_DRAIN;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (inflight_q == 2'd0) begin
          state_d   = ST_DISABLE;
          dis_cnt_d = DIS_LOAD_C;
        end
      end

      ST_DISABLE: begin
        if (dis_cnt_q == 2'd0) begin
          state_d    = ST_PROGRAM;
          rd_addr_d  = '0;
          rd_left_d  = NUM_TAPS_C;
          tap_left_d = NUM_TAPS_C;
        end else begin
          dis_cnt_d = dis_cnt_q - 2'd1;
        end
      end

      ST_PROGRAM: begin
        // Fetch the next tap when the output slot is empty or being consumed,
        // so taps stream back-to-back while tap_dout_ready stays high.
        if (rd_left_q != '0 && (!tap_vld_q || tap_hs)) begin
          rd_en     = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
        end
        if (rd_en) begin
          tap_vld_d = 1'b1;
        end else if (tap_hs) begin
          tap_vld_d = 1'b0;
        end
        if (tap_hs) begin
          tap_left_d = tap_left_q - 1'b1;
          if (tap_left_q == CW'(1)) begin
            state_d  = ST_RUN;
            active_d = bank_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
      bank_q     <= '0;
      active_q   <= '0;
      inflight_q <= '0;
      dis_cnt_q  <= '0;
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      tap_left_q <= '0;
      tap_vld_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      bank_q     <= bank_d;
      active_q   <= active_d;
      inflight_q <= inflight_d;
      dis_cnt_q  <= dis_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_left_q  <= rd_left_d;
      tap_left_q <= tap_left_d;
      tap_vld_q  <= tap_vld_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
module tb_fir_tap_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_wr_bank;
  logic [3:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic        cfg_wr_valid;
  logic [2:0]  load_bank;
  logic        load_valid;
  logic        load_ready;
  logic        load_err;
  logic [1:0]  active_bank;
  logic        busy;
  logic [15:0] s_din;
  logic        s_din_valid;
  logic        s_din_ready;
  logic [15:0] fir_din;
  logic        fir_din_valid;
  logic        fir_din_ready;
  logic        fir_dout_valid;
  logic        fir_dout_ready;
  logic        fir_enable;
  logic [15:0] tap_dout;
  logic        tap_dout_valid;
  logic        tap_dout_ready;

  fir_tap_loader dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_wr_bank    (cfg_wr_bank),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_valid   (cfg_wr_valid),
    .load_bank      (load_bank),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_err       (load_err),
    .active_bank    (active_bank),
    .busy           (busy),
    .s_din          (s_din),
    .s_din_valid    (s_din_valid),
    .s_din_ready    (s_din_ready),
    .fir_din        (fir_din),
    .fir_din_valid  (fir_din_valid),
    .fir_din_ready  (fir_din_ready),
    .fir_dout_valid (fir_dout_valid),
    .fir_dout_ready (fir_dout_ready),
    .fir_enable     (fir_enable),
    .tap_dout       (tap_dout),
    .tap_dout_valid (tap_dout_valid),
    .tap_dout_ready (tap_dout_ready)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_total = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem_m [4][16];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  bit          toggle_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: tap handshakes are scored at the falling edge, then the bench
  // resumes 1 time unit after the rising edge.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    if (prev_stall) begin
      chk("tap_valid_held", 32'(tap_dout_valid), 32'(1));
      chk("tap_data_held", 32'(tap_dout), 32'(prev_data));
    end
    if (tap_dout_valid && tap_dout_ready) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        chk("tap_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("tap_value", 32'(tap_dout), 32'(e));
      end
    end
    prev_stall = tap_dout_valid && !tap_dout_ready;
    prev_data  = tap_dout;
    @(posedge clk);
    #1;
    if (toggle_rdy) tap_dout_ready = ~tap_dout_ready;
  endtask

  task automatic cfg_write(input int b, input int t, input logic [15:0] d);
    cfg_wr_bank  = 2'(b);
    cfg_wr_addr  = 4'(t);
    cfg_wr_data  = d;
    cfg_wr_valid = 1'b1;
    mem_m[b][t]  = d;
    step();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic request_load(input int b);
    load_bank  = 3'(b);
    load_valid = 1'b1;
    if (b < 4) begin
      for (int t = 0; t < 16; t++) exp_q.push_back(mem_m[b][t]);
    end
    step();
    load_valid = 1'b0;
  endtask

  // Runs until RUN; counts fir_enable-low cycles; optionally rewrites
  // bank1[15] once three taps have been accepted.
  task automatic wait_run(input string tag, input bit inj, output int zeros, output int taps);
    int cyc  = 0;
    int base = hs_total;
    bit injd = 1'b0;
    zeros = 0;
    while (busy && cyc < 200) begin
      if (!fir_enable) zeros++;
      if (inj && !injd && (hs_total - base) >= 3) begin
        cfg_wr_bank  = 2'd1;
        cfg_wr_addr  = 4'd15;
        cfg_wr_data  = 16'h7FFF;
        cfg_wr_valid = 1'b1;
        mem_m[1][15] = 16'h7FFF;
        exp_q[exp_q.size()-1] = 16'h7FFF;
        injd = 1'b1;
      end
      step();
      cfg_wr_valid = 1'b0;
      cyc++;
    end
    taps = hs_total - base;
    chk({tag, "_reach_run"}, 32'(busy), 32'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fir_enable"}, 32'(fir_enable), 32'(0));
    chk({tag, "_tap_valid"}, 32'(tap_dout_valid), 32'(0));
    chk({tag, "_tap_dout"}, 32'(tap_dout), 32'(0));
    chk({tag, "_load_ready"}, 32'(load_ready), 32'(0));
    chk({tag, "_load_err"}, 32'(load_err), 32'(0));
    chk({tag, "_active_bank"}, 32'(active_bank), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    chk({tag, "_s_din_ready"}, 32'(s_din_ready), 32'(0));
    chk({tag, "_fir_din_valid"}, 32'(fir_din_valid), 32'(0));
  endtask

  initial begin
    int zeros;
    int taps;
    int cyc;
    int base;

    reset          = 1'b0;
    cfg_wr_bank    = '0;
    cfg_wr_addr    = '0;
    cfg_wr_data    = '0;
    cfg_wr_valid   = 1'b0;
    load_bank      = '0;
    load_valid     = 1'b0;
    s_din          = 16'hBEEF;
    s_din_valid    = 1'b1;
    fir_din_ready  = 1'b1;
    fir_dout_valid = 1'b0;
    fir_dout_ready = 1'b0;
    tap_dout_ready = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int t = 0; t < 16; t++) mem_m[b][t] = '0;

    #2;
    chk_reset_outputs("por");
    step();
    step();
    chk_reset_outputs("por_held");

    // Release between edges: load_ready rises only after the next edge.
    reset = 1'b1;
    #1;
    chk("release_lr_before_edge", 32'(load_ready), 32'(0));
    step();
    chk("release_lr_after_edge", 32'(load_ready), 32'(1));
    chk("idle_fir_din_valid", 32'(fir_din_valid), 32'(0));
    chk("idle_s_din_ready", 32'(s_din_ready), 32'(0));
    chk("idle_fir_enable", 32'(fir_enable), 32'(0));
    s_din_valid   = 1'b0;
    fir_din_ready = 1'b0;

    for (int t = 0; t < 16; t++) begin
      cfg_write(0, t, 16'(16'h0100 + t));
      cfg_write(1, t, 16'(16'h0200 + 3 * t));
      cfg_write(2, t, 16'(t + 1));
      cfg_write(3, t, 16'(16'hA000 ^ t));
    end

    // Out-of-range bank from IDLE.
    base = hs_total;
    request_load(7);
    chk("err7_pulse", 32'(load_err), 32'(1));
    chk("err7_busy", 32'(busy), 32'(1));
    chk("err7_idle_enable", 32'(fir_enable), 32'(0));
    chk("err7_idle_ready", 32'(load_ready), 32'(1));
    step();
    chk("err7_pulse_end", 32'(load_err), 32'(0));
    for (int i = 0; i < 6; i++) step();
    chk("err7_no_taps", 32'(hs_total - base), 32'(0));
    chk("err7_still_idle", 32'(fir_enable), 32'(0));

    // Bank 2 from IDLE with continuous ready.
    request_load(2);
    chk("b2_drain_ready", 32'(load_ready), 32'(0));
    wait_run("b2", 1'b0, zeros, taps);
    chk("b2_taps", 32'(taps), 32'(16));
    chk("b2_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("b2_disable_cycles", 32'(zeros), 32'(2));
    chk("b2_active_bank", 32'(active_bank), 32'(2));
    chk("b2_run_enable", 32'(fir_enable), 32'(1));

    // Bank 4 is one past the last bank: rejected without leaving RUN.
    request_load(4);
    chk("err4_pulse", 32'(load_err), 32'(1));
    chk("err4_busy", 32'(busy), 32'(0));
    step();
    chk("err4_pulse_end", 32'(load_err), 32'(0));
    chk("err4_active_bank", 32'(active_bank), 32'(2));

    // Sample accepted on the same cycle as the load of bank 1.
    s_din         = 16'h1234;
    s_din_valid   = 1'b1;
    fir_din_ready = 1'b1;
    #1;
    chk("run_fir_din_valid", 32'(fir_din_valid), 32'(1));
    chk("run_s_din_ready", 32'(s_din_ready), 32'(1));
    chk("run_fir_din", 32'(fir_din), 32'(16'h1234));
    request_load(1);
    for (int i = 0; i < 3; i++) begin
      chk("drain_fir_din_valid", 32'(fir_din_valid), 32'(0));
      chk("drain_s_din_ready", 32'(s_din_ready), 32'(0));
      chk("drain_enable", 32'(fir_enable), 32'(1));
      chk("drain_busy", 32'(busy), 32'(1));
      step();
    end
    s_din_valid    = 1'b0;
    fir_dout_valid = 1'b1;
    fir_dout_ready = 1'b1;
    step();
    fir_dout_valid = 1'b0;
    fir_dout_ready = 1'b0;
    chk("drain_last_enable", 32'(fir_enable), 32'(1));
    wait_run("b1", 1'b1, zeros, taps);
    chk("b1_disable_cycles", 32'(zeros), 32'(2));
    chk("b1_taps", 32'(taps), 32'(16));
    chk("b1_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("b1_active_bank", 32'(active_bank), 32'(1));
    fir_din_ready = 1'b0;

    // Bank 3 with tap_dout_ready toggling every cycle.
    toggle_rdy = 1'b1;
    request_load(3);
    wait_run("b3", 1'b0, zeros, taps);
    toggle_rdy     = 1'b0;
    tap_dout_ready = 1'b1;
    chk("b3_taps", 32'(taps), 32'(16));
    chk("b3_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("b3_active_bank", 32'(active_bank), 32'(3));

    // Reset in the middle of streaming bank 0.
    request_load(0);
    base = hs_total;
    cyc  = 0;
    while ((hs_total - base) < 8 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("b0_reached_tap8", 32'(hs_total - base), 32'(8));
    s_din_valid   = 1'b1;
    fir_din_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    prev_stall = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("mid_release_lr", 32'(load_ready), 32'(0));
    step();
    chk("mid_release_lr_edge", 32'(load_ready), 32'(1));
    s_din_valid   = 1'b0;
    fir_din_ready = 1'b0;
    request_load(0);
    wait_run("b0", 1'b0, zeros, taps);
    chk("b0_taps", 32'(taps), 32'(16));
    chk("b0_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("b0_active_bank", 32'(active_bank), 32'(0));
    chk("b0_disable_cycles", 32'(zeros), 32'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
